// File: rtl/pe_grid_pkg.sv
// Shared definitions for the PE grid: command codes, sequencer states and
// the per-command step count.
package pe_grid_pkg;

    localparam logic [2:0] CMD_NOP        = 3'b000;
    localparam logic [2:0] CMD_SHIFT1     = 3'b001;
    localparam logic [2:0] CMD_LONG_SHIFT = 3'b010;
    localparam logic [2:0] CMD_MAC        = 3'b011;
    localparam logic [2:0] CMD_CLEAR_ACC  = 3'b100;
    localparam logic [2:0] CMD_LOAD_AB    = 3'b101;
    localparam logic [2:0] CMD_LOAD_ACC   = 3'b110;
    localparam logic [2:0] CMD_RSVD       = 3'b111;

    // Step counter width; comfortably covers any practical LONG_SHIFT.
    localparam int STEP_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Number of execute cycles a command occupies. Only LONG_SHIFT is
    // multi-step; everything else (including the reserved code) takes one.
    function automatic logic [STEP_W-1:0] steps_for(input logic [2:0]        cmd,
                                                    input logic [STEP_W-1:0] long_steps);
        steps_for = (cmd == CMD_LONG_SHIFT) ? long_steps : STEP_W'(1);
    endfunction

endpackage

// File: rtl/pe_grid_nxm_pe_cell.sv
// Single processing element: A/B operand registers and an accumulator.
// Shift inputs come from the neighbour chosen by the grid wiring; the cell
// only decides which image moves.
module pe_cell
    import pe_grid_pkg::*;
#(
    parameter int PRECISION        = 8,
    parameter int OUTPUT_PRECISION = 32,
    parameter int SIGNED           = 0
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        ld_ab,
    input  logic                        ld_acc,
    input  logic                        clr,
    input  logic                        mac,
    input  logic                        shift_en,
    input  logic                        shift_sel,
    input  logic [PRECISION-1:0]        shift_a_in,
    input  logic [PRECISION-1:0]        shift_b_in,
    input  logic [PRECISION-1:0]        a_load,
    input  logic [PRECISION-1:0]        b_load,
    input  logic [OUTPUT_PRECISION-1:0] acc_load,
    output logic [PRECISION-1:0]        a_out,
    output logic [PRECISION-1:0]        b_out,
    output logic [OUTPUT_PRECISION-1:0] acc_out
);

    localparam int PW = 2 * PRECISION;

    logic [PRECISION-1:0]        a_reg, a_next;
    logic [PRECISION-1:0]        b_reg, b_next;
    logic [OUTPUT_PRECISION-1:0] acc_reg, acc_next;

    logic                        a_sgn, b_sgn, prod_sgn;
    logic [PW-1:0]               a_x, b_x, prod;
    logic [OUTPUT_PRECISION-1:0] prod_ext;

    // Extending both operands to the full product width (sign or zero)
    // lets a plain multiply yield the correct low 2*PRECISION bits in
    // either mode.
    assign a_sgn    = (SIGNED != 0) & a_reg[PRECISION-1];
    assign b_sgn    = (SIGNED != 0) & b_reg[PRECISION-1];
    assign a_x      = {{PRECISION{a_sgn}}, a_reg};
    assign b_x      = {{PRECISION{b_sgn}}, b_reg};
    assign prod     = a_x * b_x;
    assign prod_sgn = (SIGNED != 0) & prod[PW-1];

    generate
        if (OUTPUT_PRECISION > PW) begin : g_ext
            assign prod_ext = {{(OUTPUT_PRECISION-PW){prod_sgn}}, prod};
        end else begin : g_noext
            assign prod_ext = prod[OUTPUT_PRECISION-1:0];
        end
    endgenerate

    // Next-state selection for operands and accumulator; the sequencer
    // raises at most one of these controls per cycle.
    always_comb begin
        a_next   = a_reg;
        b_next   = b_reg;
        acc_next = acc_reg;
        if (ld_ab) begin
            a_next = a_load;
            b_next = b_load;
        end else if (shift_en) begin
            if (shift_sel) begin
                b_next = shift_b_in;
            end else begin
                a_next = shift_a_in;
            end
        end
        if (clr) begin
            acc_next = '0;
        end else if (ld_acc) begin
            acc_next = acc_load;
        end else if (mac) begin
            acc_next = acc_reg + prod_ext;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (srst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
        end else begin
            a_reg   <= a_next;
            b_reg   <= b_next;
            acc_reg <= acc_next;
        end
    end

    assign a_out   = a_reg;
    assign b_out   = b_reg;
    assign acc_out = acc_reg;

endmodule

// File: rtl/pe_grid_nxm.sv
// ROWS x COLS processing-element grid with a command sequencer.
// A command is accepted when ready && array_ack, then executes one step per
// cycle for its step count. A shifts left along rows, B shifts up along
// columns.
// Build option: define PE_GRID_WRAP_EN for toroidal shifts; otherwise the
// edge PE fills with zero.
module pe_grid_nxm
    import pe_grid_pkg::*;
#(
    parameter int ROWS             = 4,
    parameter int COLS             = 4,
    parameter int PRECISION        = 8,
    parameter int OUTPUT_PRECISION = 32,
    parameter int LONG_SHIFT       = 4,
    parameter int SIGNED           = 0
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [2:0]                             command_to_execute,
    input  logic                                   image_to_shift,
    input  logic                                   array_ack,
    input  logic [ROWS*COLS*PRECISION-1:0]         a_overwrite,
    input  logic [ROWS*COLS*PRECISION-1:0]         b_overwrite,
    input  logic [ROWS*COLS*OUTPUT_PRECISION-1:0]  s_out_overwrite_array,
    output logic                                   ready,
    output logic [ROWS*COLS*PRECISION-1:0]         A_array,
    output logic [ROWS*COLS*PRECISION-1:0]         B_array,
    output logic [ROWS*COLS*OUTPUT_PRECISION-1:0]  s_out_array
);

    localparam int NPE = ROWS * COLS;

    state_t              state_reg, state_next;
    logic [2:0]          cmd_reg, cmd_next;
    logic                img_reg, img_next;
    logic [STEP_W-1:0]   cnt_reg, cnt_next;

    logic exec;
    logic do_shift, do_mac, do_clr, do_ld_ab, do_ld_acc;

    logic [PRECISION-1:0]        a_cell   [NPE];
    logic [PRECISION-1:0]        b_cell   [NPE];
    logic [OUTPUT_PRECISION-1:0] acc_cell [NPE];
    logic [PRECISION-1:0]        a_nbr    [NPE];
    logic [PRECISION-1:0]        b_nbr    [NPE];

    // Sequencer state register; reset aborts any command in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cmd_reg   <= CMD_NOP;
            img_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            img_reg   <= img_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: latch the command on accept, count steps down in EXEC.
    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        img_next   = img_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (array_ack) begin
                    state_next = EXEC;
                    cmd_next   = command_to_execute;
                    img_next   = image_to_shift;
                    cnt_next   = steps_for(command_to_execute, STEP_W'(LONG_SHIFT));
                end
            end
            EXEC: begin
                cnt_next = cnt_reg - STEP_W'(1);
                if (cnt_reg <= STEP_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready     = (state_reg == IDLE);
    assign exec      = (state_reg == EXEC);
    assign do_shift  = exec && ((cmd_reg == CMD_SHIFT1) || (cmd_reg == CMD_LONG_SHIFT));
    assign do_mac    = exec && (cmd_reg == CMD_MAC);
    assign do_clr    = exec && (cmd_reg == CMD_CLEAR_ACC);
    assign do_ld_ab  = exec && (cmd_reg == CMD_LOAD_AB);
    assign do_ld_acc = exec && (cmd_reg == CMD_LOAD_ACC);

    genvar gi;
    generate
        for (gi = 0; gi < NPE; gi++) begin : g_pe
            localparam int R = gi / COLS;
            localparam int C = gi % COLS;

            // A neighbour: the PE to the right, or the edge fill.
            if (C == COLS - 1) begin : g_a_edge
`ifdef PE_GRID_WRAP_EN
                assign a_nbr[gi] = a_cell[gi - (COLS - 1)];
`else
                assign a_nbr[gi] = '0;
`endif
            end else begin : g_a_in
                assign a_nbr[gi] = a_cell[gi + 1];
            end

            // B neighbour: the PE below, or the edge fill.
            if (R == ROWS - 1) begin : g_b_edge
`ifdef PE_GRID_WRAP_EN
                assign b_nbr[gi] = b_cell[C];
`else
                assign b_nbr[gi] = '0;
`endif
            end else begin : g_b_in
                assign b_nbr[gi] = b_cell[gi + COLS];
            end

            pe_cell #(
                .PRECISION       (PRECISION),
                .OUTPUT_PRECISION(OUTPUT_PRECISION),
                .SIGNED          (SIGNED)
            ) u_cell (
                .clk       (CLK),
                .srst      (RST),
                .ld_ab     (do_ld_ab),
                .ld_acc    (do_ld_acc),
                .clr       (do_clr),
                .mac       (do_mac),
                .shift_en  (do_shift),
                .shift_sel (img_reg),
                .shift_a_in(a_nbr[gi]),
                .shift_b_in(b_nbr[gi]),
                .a_load    (a_overwrite[gi*PRECISION +: PRECISION]),
                .b_load    (b_overwrite[gi*PRECISION +: PRECISION]),
                .acc_load  (s_out_overwrite_array[gi*OUTPUT_PRECISION +: OUTPUT_PRECISION]),
                .a_out     (a_cell[gi]),
                .b_out     (b_cell[gi]),
                .acc_out   (acc_cell[gi])
            );

            assign A_array[gi*PRECISION +: PRECISION]                  = a_cell[gi];
            assign B_array[gi*PRECISION +: PRECISION]                  = b_cell[gi];
            assign s_out_array[gi*OUTPUT_PRECISION +: OUTPUT_PRECISION] = acc_cell[gi];
        end
    endgenerate

endmodule

// File: tb/tb_pe_grid_nxm.sv
// Testbench for pe_grid_nxm: an unsigned and a signed instance share the
// same stimulus; a reference model pushes expected images to a scoreboard
// queue when each command is issued, popped when the command completes.
module tb_pe_grid_nxm;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int P  = 8;
    localparam int OP = 32;
    localparam int LS = 4;
    localparam int N  = R * C;
`ifdef PE_GRID_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]      cmd = 3'b000;
    logic            img = 1'b0;
    logic            ack = 1'b0;
    logic [N*P-1:0]  a_ow = '0;
    logic [N*P-1:0]  b_ow = '0;
    logic [N*OP-1:0] acc_ow = '0;

    logic            ready_u, ready_s;
    logic [N*P-1:0]  A_u, B_u, A_s, B_s;
    logic [N*OP-1:0] S_u, S_s;

    pe_grid_nxm #(.ROWS(R), .COLS(C), .PRECISION(P), .OUTPUT_PRECISION(OP),
                  .LONG_SHIFT(LS), .SIGNED(0)) dut_u (
        .CLK(clk), .RST(rst), .command_to_execute(cmd), .image_to_shift(img),
        .array_ack(ack), .a_overwrite(a_ow), .b_overwrite(b_ow),
        .s_out_overwrite_array(acc_ow), .ready(ready_u),
        .A_array(A_u), .B_array(B_u), .s_out_array(S_u));

    pe_grid_nxm #(.ROWS(R), .COLS(C), .PRECISION(P), .OUTPUT_PRECISION(OP),
                  .LONG_SHIFT(LS), .SIGNED(1)) dut_s (
        .CLK(clk), .RST(rst), .command_to_execute(cmd), .image_to_shift(img),
        .array_ack(ack), .a_overwrite(a_ow), .b_overwrite(b_ow),
        .s_out_overwrite_array(acc_ow), .ready(ready_s),
        .A_array(A_s), .B_array(B_s), .s_out_array(S_s));

    // Reference model state
    logic [P-1:0]  ma [N];
    logic [P-1:0]  mb [N];
    logic [OP-1:0] mu [N];
    logic [OP-1:0] ms [N];

    typedef struct {
        logic [N*P-1:0]  a;
        logic [N*P-1:0]  b;
        logic [N*OP-1:0] su;
        logic [N*OP-1:0] ss;
        int              steps;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            ma[i] = '0; mb[i] = '0; mu[i] = '0; ms[i] = '0;
        end
    endtask

    task automatic model_apply(input logic [2:0] c, input logic im);
        logic [P-1:0] na [N];
        int reps;
        int sa, sbv;
        reps = (c == 3'b010) ? LS : 1;
        case (c)
            3'b001, 3'b010: begin
                for (int k = 0; k < reps; k++) begin
                    for (int r = 0; r < R; r++) begin
                        for (int cc = 0; cc < C; cc++) begin
                            if (!im) begin
                                if (cc < C - 1) na[r*C+cc] = ma[r*C+cc+1];
                                else            na[r*C+cc] = WRAP ? ma[r*C] : '0;
                            end else begin
                                if (r < R - 1)  na[r*C+cc] = mb[(r+1)*C+cc];
                                else            na[r*C+cc] = WRAP ? mb[cc] : '0;
                            end
                        end
                    end
                    for (int i = 0; i < N; i++) begin
                        if (!im) ma[i] = na[i];
                        else     mb[i] = na[i];
                    end
                end
            end
            3'b011: begin
                for (int i = 0; i < N; i++) begin
                    mu[i] = mu[i] + 32'(ma[i]) * 32'(mb[i]);
                    sa    = $signed(ma[i]);
                    sbv   = $signed(mb[i]);
                    ms[i] = ms[i] + 32'(sa * sbv);
                end
            end
            3'b100: for (int i = 0; i < N; i++) begin mu[i] = '0; ms[i] = '0; end
            3'b101: for (int i = 0; i < N; i++) begin
                        ma[i] = a_ow[i*P +: P];
                        mb[i] = b_ow[i*P +: P];
                    end
            3'b110: for (int i = 0; i < N; i++) begin
                        mu[i] = acc_ow[i*OP +: OP];
                        ms[i] = acc_ow[i*OP +: OP];
                    end
            default: ;
        endcase
    endtask

    task automatic push_expected(input logic [2:0] c, input logic im);
        exp_t x;
        model_apply(c, im);
        for (int i = 0; i < N; i++) begin
            x.a[i*P +: P]    = ma[i];
            x.b[i*P +: P]    = mb[i];
            x.su[i*OP +: OP] = mu[i];
            x.ss[i*OP +: OP] = ms[i];
        end
        x.steps = (c == 3'b010) ? LS : 1;
        sb.push_back(x);
    endtask

    // Issue one command with a single-cycle ack, then count busy cycles
    // until ready returns (-1 if it never does within the budget).
    task automatic run_cmd(input logic [2:0] c, input logic im, output int nb);
        push_expected(c, im);
        @(negedge clk);
        cmd = c; img = im; ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack = 1'b0;
        nb = 0;
        while (ready_u !== 1'b1 && nb < 50) begin
            @(negedge clk);
            nb++;
        end
        if (nb >= 50) nb = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_checks++;
        if ({ready_u, ready_s} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b, want 11", {ready_u, ready_s});
        end
        n_checks++;
        if ({A_u, B_u, S_u, A_s, B_s, S_s} !== '0) begin
            n_fail++; $display("FAIL reset_zero: A=%h B=%h not all zero", A_u, B_u);
        end
        $display("reset: ready=%b", ready_u);
    endtask

    task automatic test_load_ab();
        a_ow = {N{8'h01}};
        b_ow = {N{8'h01}};
        run_cmd(3'b101, 1'b0, busy);
        e = sb.pop_front();
        n_checks++;
        if (busy !== 1) begin n_fail++; $display("FAIL load_ab_busy: got %0d, want 1", busy); end
        n_checks++;
        if (A_u !== {N{8'h01}} || B_u !== {N{8'h01}} || A_s !== e.a || B_s !== e.b) begin
            n_fail++; $display("FAIL load_ab_img: A=%h B=%h, want all 01", A_u, B_u);
        end
        n_checks++;
        if (S_u !== '0 || S_s !== '0) begin n_fail++; $display("FAIL load_ab_acc: got %h, want 0", S_u); end
        $display("load_ab: busy=%0d A=%h", busy, A_u);
    endtask

    task automatic test_shift1();
        for (int i = 0; i < N; i++) begin
            a_ow[i*P +: P] = 8'(i);
            b_ow[i*P +: P] = 8'(8'h40 + i);
        end
        run_cmd(3'b101, 1'b0, busy);
        e = sb.pop_front();
        run_cmd(3'b001, 1'b0, busy);
        e = sb.pop_front();
        n_checks++;
        if (A_u !== e.a || B_u !== e.b) begin
            n_fail++; $display("FAIL shift1_a: A=%h B=%h, want A=%h B=%h", A_u, B_u, e.a, e.b);
        end
        n_checks++;
        if (A_u[(1*C+3)*P +: P] !== (WRAP ? 8'd4 : 8'd0) || A_u[(2*C+1)*P +: P] !== 8'd10) begin
            n_fail++; $display("FAIL shift1_a_edge: PE(1,3)=%h PE(2,1)=%h", A_u[(1*C+3)*P +: P], A_u[(2*C+1)*P +: P]);
        end
        $display("shift1 A: busy=%0d A=%h", busy, A_u);
        run_cmd(3'b001, 1'b1, busy);
        e = sb.pop_front();
        n_checks++;
        if (B_u !== e.b || A_u !== e.a || B_s !== e.b) begin
            n_fail++; $display("FAIL shift1_b: B=%h A=%h, want B=%h A=%h", B_u, A_u, e.b, e.a);
        end
        $display("shift1 B: busy=%0d B=%h", busy, B_u);
    endtask

    task automatic test_long_shift();
        run_cmd(3'b101, 1'b0, busy);
        e = sb.pop_front();
        run_cmd(3'b010, 1'b1, busy);
        e = sb.pop_front();
        n_checks++;
        if (busy !== LS) begin n_fail++; $display("FAIL long_shift_busy: got %0d, want %0d", busy, LS); end
        n_checks++;
        if (B_u !== (WRAP ? b_ow : '0) || B_u !== e.b || A_u !== a_ow) begin
            n_fail++; $display("FAIL long_shift_b: B=%h A=%h, want B=%h", B_u, A_u, e.b);
        end
        $display("long_shift B: busy=%0d B=%h", busy, B_u);
        run_cmd(3'b010, 1'b0, busy);
        e = sb.pop_front();
        n_checks++;
        if (A_u !== (WRAP ? a_ow : '0) || A_u !== e.a || busy !== LS) begin
            n_fail++; $display("FAIL long_shift_a: A=%h busy=%0d, want A=%h", A_u, busy, e.a);
        end
        $display("long_shift A: busy=%0d A=%h", busy, A_u);
    endtask

    task automatic test_nop_rsvd();
        run_cmd(3'b101, 1'b0, busy);
        e = sb.pop_front();
        for (int k = 0; k < 2; k++) begin
            run_cmd((k == 0) ? 3'b000 : 3'b111, 1'b1, busy);
            e = sb.pop_front();
            n_checks++;
            if (busy !== 1 || A_u !== e.a || B_u !== e.b || S_u !== e.su) begin
                n_fail++; $display("FAIL nop_%0d: busy=%0d A=%h B=%h", k, busy, A_u, B_u);
            end
            $display("nop/rsvd %0d: busy=%0d", k, busy);
        end
    endtask

    task automatic test_signed_mac();
        a_ow = {N{8'hFD}};
        b_ow = {N{8'h05}};
        run_cmd(3'b101, 1'b0, busy); e = sb.pop_front();
        run_cmd(3'b100, 1'b0, busy); e = sb.pop_front();
        run_cmd(3'b011, 1'b0, busy); e = sb.pop_front();
        n_checks++;
        if (S_u !== e.su || S_u[31:0] !== 32'd1265) begin
            n_fail++; $display("FAIL mac1_unsigned: got %h, want %h", S_u[31:0], e.su[31:0]);
        end
        run_cmd(3'b011, 1'b0, busy); e = sb.pop_front();
        n_checks++;
        if (S_s !== {N{32'hFFFFFFE2}} || S_s !== e.ss) begin
            n_fail++; $display("FAIL mac2_signed: got %h, want ffffffe2", S_s[31:0]);
        end
        n_checks++;
        if (S_u !== {N{32'd2530}}) begin
            n_fail++; $display("FAIL mac2_unsigned: got %h, want 000009e2", S_u[31:0]);
        end
        $display("mac x2: signed=%h unsigned=%h", S_s[31:0], S_u[31:0]);
        run_cmd(3'b100, 1'b0, busy); e = sb.pop_front();
        n_checks++;
        if (S_u !== '0 || S_s !== '0) begin
            n_fail++; $display("FAIL clear_acc: got %h/%h, want 0", S_u[31:0], S_s[31:0]);
        end
        $display("clear_acc: acc=%h", S_s[31:0]);
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        a_ow   = {N{8'h01}};
        b_ow   = {N{8'h01}};
        acc_ow = {N{32'hFFFFFFFF}};
        run_cmd(3'b101, 1'b0, busy); e = sb.pop_front();
        push_expected(3'b110, 1'b0);
        push_expected(3'b011, 1'b0);
        @(negedge clk);
        cmd = 3'b110; ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd = 3'b011;
        n_checks++;
        if (ready_u !== 1'b0) begin n_fail++; $display("FAIL b2b_busy1: ready=%b, want 0", ready_u); end
        @(negedge clk);
        e1 = sb.pop_front();
        n_checks++;
        if (ready_u !== 1'b1 || S_u !== e1.su || S_s !== {N{32'hFFFFFFFF}}) begin
            n_fail++; $display("FAIL b2b_load_acc: ready=%b acc=%h, want 1/ffffffff", ready_u, S_u[31:0]);
        end
        @(negedge clk);
        ack = 1'b0;
        n_checks++;
        if (ready_u !== 1'b0) begin n_fail++; $display("FAIL b2b_accept2: ready=%b, want 0", ready_u); end
        @(negedge clk);
        e2 = sb.pop_front();
        n_checks++;
        if (ready_u !== 1'b1 || S_u !== '0 || S_s !== e2.ss) begin
            n_fail++; $display("FAIL b2b_mac_wrap: ready=%b acc=%h, want 1/0", ready_u, S_u[31:0]);
        end
        $display("back_to_back: acc=%h ready=%b", S_u[31:0], ready_u);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cmd = 3'b010; img = 1'b0; ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_checks++;
        if (ready_u !== 1'b1 || {A_u, B_u, S_u, A_s, B_s, S_s} !== '0) begin
            n_fail++; $display("FAIL reset_mid: ready=%b A=%h S=%h, want 1/0/0", ready_u, A_u, S_u[31:0]);
        end
        a_ow = {N{8'h5A}};
        run_cmd(3'b101, 1'b0, busy);
        e = sb.pop_front();
        n_checks++;
        if (busy !== 1 || A_u !== e.a || B_u !== e.b) begin
            n_fail++; $display("FAIL after_reset_load: busy=%0d A=%h, want %h", busy, A_u, e.a);
        end
        $display("reset_mid: then load busy=%0d A=%h", busy, A_u);
    endtask

    initial begin
        test_reset();
        test_load_ab();
        test_shift1();
        test_long_shift();
        test_nop_rsvd();
        test_signed_mac();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
